// File: rtl/icache_line_fill.sv
// Instruction-cache line-fill engine: fetches a 16-byte line as four 32-bit words,
// critical word first with wrap-around, with a per-word stall timeout.
module icache_line_fill #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         miss_req,
    input  logic [31:0]  miss_addr,
    output logic         fill_busy,
    output logic         fill_valid,
    output logic [31:0]  fill_addr,
    output logic [127:0] data_line,
    output logic         fill_error,
    output logic         mem_rd,
    output logic [31:0]  mem_addr,
    input  logic [31:0]  mem_rdata,
    input  logic         mem_ready
);

    typedef enum logic [1:0] {StIdle, StReq, StDone, StErr} state_e;

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

    state_e         state_q, state_d;
    logic [31:0]    fill_addr_q, fill_addr_d;
    logic [127:0]   data_line_q, data_line_d;
    logic [1:0]     widx_q, widx_d;
    logic [1:0]     wcnt_q, wcnt_d;
    logic [7:0]     tcnt_q, tcnt_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            fill_addr_q <= '0;
            data_line_q <= '0;
            widx_q      <= '0;
            wcnt_q      <= '0;
            tcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            fill_addr_q <= fill_addr_d;
            data_line_q <= data_line_d;
            widx_q      <= widx_d;
            wcnt_q      <= wcnt_d;
            tcnt_q      <= tcnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fill_addr_d = fill_addr_q;
        data_line_d = data_line_q;
        widx_d      = widx_q;
        wcnt_d      = wcnt_q;
        tcnt_d      = tcnt_q;
        unique case (state_q)
            StIdle: begin
                if (miss_req) begin
                    fill_addr_d = {miss_addr[31:4], 4'b0000};
                    widx_d      = miss_addr[3:2];
                    wcnt_d      = 2'd0;
                    tcnt_d      = 8'd0;
                    state_d     = StReq;
                end
            end
            StReq: begin
                // A transfer takes priority over a timeout on the same edge.
                if (mem_ready) begin
                    data_line_d[{widx_q, 5'b00000} +: 32] = mem_rdata;
                    widx_d = widx_q + 2'd1;
                    wcnt_d = wcnt_q + 2'd1;
                    tcnt_d = 8'd0;
                    if (wcnt_q == 2'd3) begin
                        state_d = StDone;
                    end
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                    if (tcnt_q == TimeoutLast) begin
                        state_d = StErr;
                    end
                end
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs depend only on registered state, never on mem_ready/miss_req.
    always_comb begin
        fill_busy  = (state_q != StIdle);
        fill_valid = (state_q == StDone);
        fill_error = (state_q == StErr);
        mem_rd     = (state_q == StReq);
        mem_addr   = {fill_addr_q[31:4], widx_q, 2'b00};
        fill_addr  = fill_addr_q;
        data_line  = data_line_q;
    end

endmodule

// File: tb/tb_icache_line_fill.sv
// Self-checking bench for icache_line_fill: directed test-plan cases plus randomized
// fills with random wait states, checked against a word-order/line reference model.
module tb_icache_line_fill;

    localparam int unsigned T = 8;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         miss_req = 1'b0;
    logic [31:0]  miss_addr = '0;
    logic         fill_busy, fill_valid, fill_error, mem_rd;
    logic [31:0]  fill_addr, mem_addr;
    logic [127:0] data_line;
    logic [31:0]  mem_rdata = '0;
    logic         mem_ready = 1'b0;

    int n_total = 0;
    int n_bad   = 0;
    int stl[4];
    bit directed = 1'b0;

    icache_line_fill #(.TIMEOUT_CYCLES(T)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .miss_req   (miss_req),
        .miss_addr  (miss_addr),
        .fill_busy  (fill_busy),
        .fill_valid (fill_valid),
        .fill_addr  (fill_addr),
        .data_line  (data_line),
        .fill_error (fill_error),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (directed) return 32'h0000_00A0 + 32'(a[3:2]);
        return {a[31:16] ^ a[15:0], a[15:0]} ^ 32'h5A5A_1234;
    endfunction

    // Called and returns at a negedge. stl[k] = stall cycles before the k-th word in
    // arrival order; T or more stalls on one word must abort the fill.
    task automatic run_fill(input logic [31:0] addr, input bit hold, input logic [31:0] alt);
        logic [31:0] base;
        logic [31:0] line [4];
        logic [31:0] a;
        logic [127:0] exp_line;
        int w;
        bit err;
        base = {addr[31:4], 4'b0000};
        err = 1'b0;
        for (int k = 0; k < 4; k++) line[k] = '0;
        miss_req  = 1'b1;
        miss_addr = addr;
        mem_ready = 1'b0;
        @(negedge clock);
        if (hold) miss_addr = alt;
        else begin
            miss_req  = 1'b0;
            miss_addr = $urandom;
        end
        check("busy_after_accept", 128'(fill_busy), 128'd1);
        for (int k = 0; k < 4 && !err; k++) begin
            w = (int'(addr[3:2]) + k) % 4;
            a = base + 32'(4 * w);
            for (int s = 0; s < stl[k] && !err; s++) begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
                check("mem_rd_stall", 128'(mem_rd), 128'd1);
                check("mem_addr_stall", 128'(mem_addr), 128'(a));
                check("no_valid_stall", 128'(fill_valid), 128'd0);
                @(negedge clock);
                if (s == int'(T) - 1) err = 1'b1;
            end
            if (!err) begin
                mem_ready = 1'b1;
                mem_rdata = mem_word(a);
                line[w]   = mem_rdata;
                check("mem_rd_xfer", 128'(mem_rd), 128'd1);
                check("mem_addr_xfer", 128'(mem_addr), 128'(a));
                check("no_error_xfer", 128'(fill_error), 128'd0);
                @(negedge clock);
            end
        end
        mem_ready = 1'b0;
        exp_line = {line[3], line[2], line[1], line[0]};
        if (err) begin
            check("err_pulse", 128'(fill_error), 128'd1);
            check("err_no_valid", 128'(fill_valid), 128'd0);
            check("err_mem_rd", 128'(mem_rd), 128'd0);
        end else begin
            check("valid_pulse", 128'(fill_valid), 128'd1);
            check("valid_no_err", 128'(fill_error), 128'd0);
            check("done_mem_rd", 128'(mem_rd), 128'd0);
            check("data_line", data_line, exp_line);
            check("fill_addr", 128'(fill_addr), 128'(base));
        end
        @(negedge clock);
        check("pulse_end_valid", 128'(fill_valid), 128'd0);
        check("pulse_end_err", 128'(fill_error), 128'd0);
        check("idle_busy", 128'(fill_busy), 128'd0);
        check("idle_mem_rd", 128'(mem_rd), 128'd0);
        if (!err) begin
            check("line_held", data_line, exp_line);
            check("addr_held", 128'(fill_addr), 128'(base));
        end
    endtask

    task automatic set_stalls(input int s0, input int s1, input int s2, input int s3);
        stl[0] = s0; stl[1] = s1; stl[2] = s2; stl[3] = s3;
    endtask

    initial begin
        #12;
        check("rst_busy", 128'(fill_busy), 128'd0);
        check("rst_valid", 128'(fill_valid), 128'd0);
        check("rst_error", 128'(fill_error), 128'd0);
        check("rst_mem_rd", 128'(mem_rd), 128'd0);
        check("rst_mem_addr", 128'(mem_addr), 128'd0);
        check("rst_fill_addr", 128'(fill_addr), 128'd0);
        check("rst_line", data_line, 128'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // Aligned zero-wait fill with the A0+k pattern.
        directed = 1'b1;
        set_stalls(0, 0, 0, 0);
        run_fill(32'h0000_0040, 1'b0, 32'h0);
        check("tp_line_40", data_line, 128'h000000A3_000000A2_000000A1_000000A0);
        directed = 1'b0;

        // Critical word first with wrap.
        run_fill(32'h0000_123C, 1'b0, 32'h0);

        // Three wait states before every word.
        set_stalls(3, 3, 3, 3);
        run_fill(32'h0000_0080, 1'b0, 32'h0);

        // Timeout on the first word, then a transfer landing on the last allowed stall.
        set_stalls(20, 0, 0, 0);
        run_fill(32'h0000_0500, 1'b0, 32'h0);
        set_stalls(0, int'(T) - 1, 0, int'(T) - 1);
        run_fill(32'h0000_0604, 1'b0, 32'h0);

        // Reset mid-fill after two words.
        miss_req  = 1'b1;
        miss_addr = 32'h0000_0180;
        @(negedge clock);
        miss_req  = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        @(negedge clock);
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_mem_rd", 128'(mem_rd), 128'd0);
        check("mid_rst_busy", 128'(fill_busy), 128'd0);
        check("mid_rst_valid", 128'(fill_valid), 128'd0);
        check("mid_rst_error", 128'(fill_error), 128'd0);
        check("mid_rst_fill_addr", 128'(fill_addr), 128'd0);
        check("mid_rst_mem_addr", 128'(mem_addr), 128'd0);
        check("mid_rst_line", data_line, 128'd0);
        mem_ready = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        set_stalls(0, 0, 0, 0);
        run_fill(32'h0000_0200, 1'b0, 32'h0);

        // Back-to-back: request held high, address changed during the first fill.
        run_fill(32'h0000_0100, 1'b1, 32'h0000_0300);
        run_fill(32'h0000_0300, 1'b0, 32'h0);

        // Randomized fills with occasional timeouts.
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 11) == 0) stl[k] = int'($urandom_range(T, T + 2));
                else stl[k] = int'($urandom_range(0, 3));
            end
            run_fill($urandom, 1'b0, 32'h0);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clock);
                check("gap_mem_rd", 128'(mem_rd), 128'd0);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/icache_line_fill.md
# icache_line_fill

Line-fill engine between the instruction cache and the 32-bit word-wide main memory of the multicycle MIPS. On a cache miss it fetches the four words of the 16-byte line containing the missing address, critical word first with wrap-around. It assembles them into the 128-bit `data_line` that the cache writes into its storage. A per-word timeout keeps a missing memory response from hanging the fetch path.

## Interface
- `TIMEOUT_CYCLES`, default 255: consecutive stalled cycles on one word before the fill aborts; legal range 1..255.
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `miss_req` in 1: level request from cache; sampled only in IDLE.
- `miss_addr` in 32: missing instruction byte address; sampled with `miss_req`.
- `fill_busy` out 1: high in every state except IDLE.
- `fill_valid` out 1: one-cycle pulse; `data_line`/`fill_addr` hold a complete line.
- `fill_addr` out 32: line-aligned base, `{miss_addr[31:4],4'b0000}`.
- `data_line` out 128: word k of the line in bits `[32k+31:32k]`.
- `fill_error` out 1: one-cycle pulse on timeout abort.
- `mem_rd` out 1: memory read request.
- `mem_addr` out 32: word address `fill_addr + 4*widx`; bits [1:0] always 0.
- `mem_rdata` in 32: read data, valid when `mem_ready` is high.
- `mem_ready` in 1: read completion; a word transfers on any edge where `mem_rd && mem_ready`.

## Operation
- FSM states: IDLE, REQ, DONE, ERR.
- IDLE with `miss_req=1`:
  - latch `fill_addr`;
  - `widx <= miss_addr[3:2]`, `wcnt <= 0`, `tcnt <= 0`;
  - go to REQ.
- REQ drives `mem_rd=1` and `mem_addr = fill_addr + {widx,2'b00}`.
- On a transfer in REQ:
  - `data_line[32*widx +: 32] <= mem_rdata`;
  - `widx <= widx+1` (2-bit, wraps 3→0);
  - `wcnt <= wcnt+1`, `tcnt <= 0`;
  - when `wcnt==3`, go to DONE instead of staying in REQ.
- Stalled cycle in REQ (`mem_ready=0`): `tcnt <= tcnt+1`.
  - If `tcnt == TIMEOUT_CYCLES-1` at that edge, go to ERR.
  - If a transfer and the timeout coincide on the same edge, the transfer wins.
- DONE: `fill_valid=1` for exactly one cycle, then IDLE. `miss_req` is ignored in DONE.
- ERR: `fill_error=1` for exactly one cycle, `mem_rd=0`, then IDLE.
  - Partially written `data_line` words are not qualified. Consumers must use `data_line` only on `fill_valid`.
- `data_line` and `fill_addr` hold their values until the next accepted miss. The cache may sample them on or after `fill_valid`.
- In REQ, changes to `miss_req`/`miss_addr` are ignored. The fill always completes for the latched line.
- `miss_req` still high in the IDLE cycle after DONE starts a new fill. The cache deasserts `miss_req` once it has written the line.

## Timing
- Reset (async assert, synchronous-to-clock deassert by system):
  - state IDLE;
  - `mem_rd`, `fill_busy`, `fill_valid`, `fill_error` = 0;
  - `mem_addr`, `fill_addr` = 0, `data_line` = 0;
  - `widx`, `wcnt`, `tcnt` = 0.
- Reset mid-fill drops `mem_rd` immediately, with no pulse on `fill_valid`/`fill_error`.
- Outputs are registered or decoded from state only. There is no combinational path from `mem_ready`/`miss_req` to any output.
- Zero-wait memory (`mem_ready` tied 1):
  - miss accepted at edge E0;
  - `mem_rd` high cycles E0–E4, one word per edge E1..E4;
  - `fill_valid` high cycle E4–E5, IDLE after E5.
  - Request-to-`fill_valid` latency is 5 cycles. The earliest next acceptance is E6.
- `mem_rd` stays high continuously across the four words. `mem_addr` changes on the edge after each transfer. The memory must treat a new address as a new read.
- With N total stall cycles, latency is 5+N.

## Test plan
- Aligned miss, zero-wait: `miss_addr=0x0000_0040`, memory returns `0xA0+k` for word k.
  - Required: `mem_addr` sequence 0x40,0x44,0x48,0x4C.
  - `fill_valid` 5 cycles after the request.
  - `data_line=0x000000A3_000000A2_000000A1_000000A0`, `fill_addr=0x40`.
- Critical-word-first wrap: `miss_addr=0x0000_123C`.
  - `mem_addr` order 0x123C,0x1230,0x1234,0x1238.
  - `data_line` words placed by index, not arrival order; `fill_addr=0x1230`.
- Wait states: `mem_ready` low 3 cycles before each word, `miss_addr=0x80`.
  - `fill_valid` at latency 17.
  - `mem_addr` holds each value for 4 cycles; data correct.
- Timeout: `TIMEOUT_CYCLES=8`, `mem_ready` never asserted.
  - `fill_error` pulses once, 9 cycles after the request.
  - `mem_rd` low in ERR; back in IDLE; `fill_valid` never asserted.
  - Separately, `mem_ready` on the 8th stalled cycle: transfer accepted, no error.
- Reset mid-fill: assert `reset_n=0` after word 2.
  - All outputs 0 asynchronously.
  - A following miss to 0x200 completes normally with correct data.
- Back-to-back: `miss_req` held high with `miss_addr` changed to 0x300 during fill of 0x100.
  - First fill returns line 0x100.
  - Second fill of 0x300 starts the cycle after DONE.
